// File: rtl/xip_cache_pkg.sv
// Shared types and width helpers for the 2-way XiP cache.
package xip_cache_pkg;

  typedef enum logic [2:0] {IDLE, FILL, DATA, ERR1, ERR2} state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic int off_w(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_sets, input int line_size);
    return addr_w - $clog2(num_sets) - $clog2(line_size);
  endfunction

endpackage

// File: rtl/xip_cache_2way_array.sv
// Tag/valid/LRU state and line storage for both ways, with lookup, fill write and word read.
module xip_cache_2way_array
  import xip_cache_pkg::*;
#(
  parameter int NUM_SETS  = 8,
  parameter int LINE_SIZE = 16,
  parameter int ADDR_W    = 24,
  localparam int OFF_W    = off_w(LINE_SIZE),
  localparam int IDX_W    = idx_w(NUM_SETS),
  localparam int TAG_W    = tag_w(ADDR_W, NUM_SETS, LINE_SIZE),
  localparam int LN_W     = ADDR_W - OFF_W,
  localparam int LINE_W   = LINE_SIZE * 8,
  localparam int WSEL_W   = OFF_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LN_W-1:0]   lk_line_i,
  output logic              hit_o,
  output logic              hit_way_o,
  input  logic              lru_upd_i,
  input  logic              wr_en_i,
  input  logic              wr_vld_i,
  input  logic [LN_W-1:0]   wr_line_addr_i,
  input  logic [LINE_W-1:0] wr_line_i,
  output logic              victim_o,
  input  logic              inv_i,
  input  logic              rd_way_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [WSEL_W-1:0] rd_wsel_i,
  output logic [31:0]       rd_word_o
);

  logic [TAG_W-1:0]         tag_q  [2][NUM_SETS];
  logic [LINE_W-1:0]        data_q [2][NUM_SETS];
  logic [1:0][NUM_SETS-1:0] vld_q;
  logic [NUM_SETS-1:0]      lru_q;   // per set: the way to replace next

  logic [IDX_W-1:0]  lk_idx, wr_idx;
  logic [TAG_W-1:0]  lk_tag, wr_tag;
  logic [1:0]        way_hit;
  logic [LINE_W-1:0] rd_line;

  assign lk_idx   = lk_line_i[IDX_W-1:0];
  assign lk_tag   = lk_line_i[LN_W-1:IDX_W];
  assign wr_idx   = wr_line_addr_i[IDX_W-1:0];
  assign wr_tag   = wr_line_addr_i[LN_W-1:IDX_W];
  assign victim_o = lru_q[wr_idx];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign way_hit[w] = vld_q[w][lk_idx] && (tag_q[w][lk_idx] == lk_tag);
  end

  assign hit_o     = |way_hit;
  assign hit_way_o = way_hit[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      lru_q <= '0;
    end else begin
      if (wr_en_i) begin
        vld_q[victim_o][wr_idx] <= wr_vld_i;
        lru_q[wr_idx]           <= ~victim_o;
      end
      if (lru_upd_i) lru_q[lk_idx] <= ~hit_way_o;
      if (inv_i) vld_q <= '0;
    end
  end

  // Contents are qualified by valid, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[victim_o][wr_idx]  <= wr_tag;
      data_q[victim_o][wr_idx] <= wr_line_i;
    end
  end

  assign rd_line = data_q[rd_way_i][rd_idx_i];

  always_comb begin
    rd_word_o = '0;
    for (int w = 0; w < LINE_SIZE / 4; w++)
      if (rd_wsel_i == WSEL_W'(w)) rd_word_o = rd_line[w*32 +: 32];
  end

endmodule

// File: rtl/xip_cache_2way_ahbl.sv
// AHB-Lite read-only XiP cache front-end: address-phase capture, FSM, fill handshake, counters.
module xip_cache_2way_ahbl
  import xip_cache_pkg::*;
#(
  parameter int NUM_SETS  = 8,
  parameter int LINE_SIZE = 16,
  parameter int ADDR_W    = 24,
  parameter int CNT_W     = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  output logic                   fill_req,
  output logic [ADDR_W-1:0]      fill_addr,
  input  logic                   fill_done,
  input  logic [LINE_SIZE*8-1:0] fill_line,
  input  logic                   inv,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);

  localparam int OFF_W  = off_w(LINE_SIZE);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int WSEL_W = OFF_W - 2;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fill_addr_q;
  logic               inv_pend_q;
  logic               rd_way_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [WSEL_W-1:0]  rd_wsel_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic accept, decode, rd_acc, hit_acc, miss_acc, fill_fire;
  logic lk_hit, lk_way, victim;
  logic unused_ok;

  assign unused_ok = ^{HADDR[31:ADDR_W], HTRANS[0]};

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign decode    = (state_q == IDLE) || (state_q == DATA) || (state_q == ERR2);
  assign rd_acc    = decode & accept & ~HWRITE;
  assign hit_acc   = rd_acc & lk_hit;
  assign miss_acc  = rd_acc & ~lk_hit;
  assign fill_fire = (state_q == FILL) & fill_done;

  xip_cache_2way_array #(
    .NUM_SETS (NUM_SETS),
    .LINE_SIZE(LINE_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk_i         (HCLK),
    .rst_i         (HRESET),
    .lk_line_i     (HADDR[ADDR_W-1:OFF_W]),
    .hit_o         (lk_hit),
    .hit_way_o     (lk_way),
    .lru_upd_i     (hit_acc),
    .wr_en_i       (fill_fire),
    .wr_vld_i      (~(inv | inv_pend_q)),
    .wr_line_addr_i(fill_addr_q[ADDR_W-1:OFF_W]),
    .wr_line_i     (fill_line),
    .victim_o      (victim),
    .inv_i         (inv),
    .rd_way_i      (rd_way_q),
    .rd_idx_i      (rd_idx_q),
    .rd_wsel_i     (rd_wsel_q),
    .rd_word_o     (HRDATA)
  );

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      IDLE, DATA, ERR2: begin
        HRESP   = (state_q == ERR2);
        state_d = IDLE;
        if (accept) state_d = HWRITE ? ERR1 : (lk_hit ? IDLE : FILL);
      end
      FILL: begin
        HREADYOUT = 1'b0;
        if (fill_done) state_d = DATA;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      inv_pend_q  <= 1'b0;
      rd_way_q    <= 1'b0;
      rd_idx_q    <= '0;
      rd_wsel_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rd_acc) begin
        rd_way_q  <= lk_way;
        rd_idx_q  <= HADDR[OFF_W +: IDX_W];
        rd_wsel_q <= HADDR[OFF_W-1:2];
      end
      if (miss_acc) fill_addr_q <= {HADDR[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (fill_fire) rd_way_q <= victim;
      // An invalidate seen during a fill must keep that line from being validated.
      if (state_q == FILL) inv_pend_q <= fill_done ? 1'b0 : (inv_pend_q | inv);
      if (cnt_clr) hit_cnt_q <= '0;
      else if (hit_acc && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (cnt_clr) miss_cnt_q <= '0;
      else if (miss_acc && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign fill_req  = (state_q == FILL);
  assign fill_addr = fill_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
